// File: rtl/pwm_duty_ctrl.sv
// Pushbutton-driven PWM duty controller: press/auto-repeat stepping with saturation,
// plus a free-running period counter that latches the new duty only at period boundaries.
module pwm_duty_ctrl #(
    parameter int WIDTH         = 8,
    parameter int STEP          = 16,
    parameter int INIT_DUTY     = 128,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pb_up,
    input  logic             pb_down,
    output logic [WIDTH-1:0] duty,
    output logic             at_limit,
    output logic             pwm_out
);

    localparam logic [WIDTH-1:0] MAX      = '1;
    localparam logic [WIDTH:0]   MAX_W    = {1'b0, MAX};
    localparam logic [WIDTH:0]   STEP_W   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] INIT     = WIDTH'(INIT_DUTY);
    localparam int               TMAX     = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int               TW       = $clog2(TMAX + 1);
    localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]    REP_LAST  = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic              dir_up, dir_up_nxt;
    logic              up_q, dn_q;
    logic              rise_up, rise_dn;
    logic              do_step, step_up, abort;
    logic [WIDTH:0]    up_sum;
    logic [WIDTH-1:0]  duty_inc, duty_dec, duty_nxt;
    logic [WIDTH-1:0]  cnt, duty_active;

    assign rise_up = pb_up & ~up_q;
    assign rise_dn = pb_down & ~dn_q;

    // Saturating step, computed one bit wider so the sum can never wrap
    assign up_sum   = {1'b0, duty} + STEP_W;
    assign duty_inc = (up_sum > MAX_W) ? MAX : up_sum[WIDTH-1:0];
    assign duty_dec = ({1'b0, duty} < STEP_W) ? '0 : duty - STEP_W[WIDTH-1:0];
    assign duty_nxt = do_step ? (step_up ? duty_inc : duty_dec) : duty;

    // Leave the held state as soon as the active button drops or the other one joins in
    assign abort = dir_up ? (~pb_up | pb_down) : (~pb_down | pb_up);

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        dir_up_nxt = dir_up;
        do_step    = 1'b0;
        step_up    = dir_up;
        case (state)
            IDLE: begin
                if (rise_up && !pb_down) begin
                    do_step    = 1'b1;
                    step_up    = 1'b1;
                    dir_up_nxt = 1'b1;
                    timer_nxt  = '0;
                    state_nxt  = HOLD;
                end else if (rise_dn && !pb_up) begin
                    do_step    = 1'b1;
                    step_up    = 1'b0;
                    dir_up_nxt = 1'b0;
                    timer_nxt  = '0;
                    state_nxt  = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (abort) begin
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end else if (timer == ((state == HOLD) ? HOLD_LAST : REP_LAST)) begin
                    do_step   = 1'b1;
                    timer_nxt = '0;
                    state_nxt = REPEAT;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // Edge registers track the level even in reset, so a held button needs a re-press
        up_q <= pb_up;
        dn_q <= pb_down;
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            dir_up      <= 1'b1;
            duty        <= INIT;
            at_limit    <= (INIT == '0) || (INIT == MAX);
            cnt         <= '0;
            duty_active <= INIT;
            pwm_out     <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            dir_up      <= dir_up_nxt;
            duty        <= duty_nxt;
            at_limit    <= (duty_nxt == '0) || (duty_nxt == MAX);
            cnt         <= cnt + WIDTH'(1);
            pwm_out     <= (cnt < duty_active);
            if (cnt == MAX)
                duty_active <= duty;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a press-duration based reference model.
module tb_pwm_duty_ctrl;

    localparam int W    = 4;
    localparam int STEP = 3;
    localparam int INIT = 8;
    localparam int HOLD = 8;
    localparam int REP  = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pb_up = 1'b0;
    logic         pb_down = 1'b0;
    logic [W-1:0] duty;
    logic         at_limit;
    logic         pwm_out;

    pwm_duty_ctrl #(
        .WIDTH(W), .STEP(STEP), .INIT_DUTY(INIT),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst(rst), .pb_up(pb_up), .pb_down(pb_down),
        .duty(duty), .at_limit(at_limit), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] duty;
        logic         lim;
        logic         pwm;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: duty, the duty in force this period, position in period,
    // which button owns the current press (0 none, 1 up, 2 down) and how long it is held.
    int m_duty, m_active, m_phase, m_dir, m_held;
    bit m_pwm, pu, pd;

    function automatic int apply_step(int d, bit up);
        int r;
        r = up ? d + STEP : d - STEP;
        if (r > MAXV) r = MAXV;
        if (r < 0) r = 0;
        return r;
    endfunction

    task automatic model_edge(bit u, bit d, bit r);
        obs_t e;
        if (r) begin
            m_duty = INIT; m_active = INIT; m_phase = 0; m_pwm = 0;
            m_dir = 0; m_held = 0;
        end else begin
            m_pwm = (m_phase < m_active);
            if (m_phase == MAXV) m_active = m_duty;
            m_phase = (m_phase + 1) % (MAXV + 1);
            if (m_dir == 0) begin
                if (u && !pu && !d) begin
                    m_duty = apply_step(m_duty, 1'b1); m_dir = 1; m_held = 0;
                end else if (d && !pd && !u) begin
                    m_duty = apply_step(m_duty, 1'b0); m_dir = 2; m_held = 0;
                end
            end else if ((m_dir == 1 && (!u || d)) || (m_dir == 2 && (!d || u))) begin
                m_dir = 0;
            end else begin
                m_held++;
                if (m_held >= HOLD && (m_held - HOLD) % REP == 0)
                    m_duty = apply_step(m_duty, m_dir == 1);
            end
        end
        pu = u; pd = d;
        e.duty = m_duty[W-1:0];
        e.lim  = (m_duty == 0) || (m_duty == MAXV);
        e.pwm  = m_pwm;
        exp_q.push_back(e);
    endtask

    task automatic drive(bit u, bit d, bit r, int n);
        repeat (n) begin
            @(negedge clk);
            pb_up = u; pb_down = d; rst = r;
            model_edge(u, d, r);
        end
    endtask

    // Monitor: every cycle's registered outputs are compared to the queued expectation
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{duty: duty, lim: at_limit, pwm: pwm_out};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got duty=%0d at_limit=%0b pwm=%0b, expected duty=%0d at_limit=%0b pwm=%0b",
                             $time, a.duty, a.lim, a.pwm, e.duty, e.lim, e.pwm);
                end
            end
        end
    end

    initial begin
        bit u, d, r;
        int n;
        drive(0, 0, 1, 3);
        drive(0, 0, 0, 40);                       // steady state at duty 8
        drive(1, 0, 0, 3); drive(0, 0, 0, 40);    // single press -> 11
        drive(0, 0, 1, 2);
        drive(1, 0, 0, 30); drive(0, 0, 0, 10);   // hold: 11, 14, 15 saturate
        drive(0, 0, 1, 2);
        repeat (3) begin                          // 8 -> 5 -> 2 -> 0
            drive(0, 1, 0, 2); drive(0, 0, 0, 2);
        end
        drive(0, 0, 0, 40);
        drive(0, 0, 1, 2);
        drive(1, 1, 0, 5); drive(0, 0, 0, 3);     // simultaneous rise
        drive(1, 0, 0, 4); drive(1, 1, 0, 3);     // conflict while in HOLD
        drive(1, 0, 0, 20); drive(0, 0, 0, 5);
        drive(0, 0, 1, 2);
        drive(1, 0, 0, 15);                       // into REPEAT
        drive(1, 0, 1, 2);                        // reset mid-press
        drive(1, 0, 0, 20); drive(0, 0, 0, 2);
        drive(1, 0, 0, 3); drive(0, 0, 0, 20);
        for (int i = 0; i < 80; i++) begin
            u = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 19) == 0);
            n = r ? $urandom_range(1, 2) : $urandom_range(1, 30);
            drive(u, d, r, n);
        end
        drive(0, 0, 0, 1);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
- Sequencing controller for the PWM datapath.
- Takes the two debounced pushbutton levels (up/down) produced by the project's debouncers and maintains the duty-cycle register, stepping it on each press and auto-repeating while a button is held.
- Contains the PWM period counter, so duty changes are applied glitch-free at period boundaries.
- Drives pwm_out directly to the LED/pin.

Parameters:
- WIDTH, 8: width of duty and PWM counter; period = 2^WIDTH clocks.
- STEP, 16: duty increment/decrement per step.
- INIT_DUTY, 128: duty value after reset.
- HOLD_CYCLES, 25_000_000: cycles a button must stay held after the first step before auto-repeat starts.
- REPEAT_CYCLES, 5_000_000: cycles between auto-repeat steps.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- pb_up  input  1  debounced up button level, 1 = pressed; synchronous to clk.
- pb_down  input  1  debounced down button level, 1 = pressed; synchronous to clk.
- duty  output  WIDTH  current target duty (registered).
- at_limit  output  1  1 when duty == 0 or duty == 2^WIDTH-1 (registered).
- pwm_out  output  1  PWM waveform (registered).

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset values:
  - duty = INIT_DUTY, duty_active (shadow) = INIT_DUTY.
  - PWM counter cnt = 0, pwm_out = 0, at_limit = (INIT_DUTY==0 || INIT_DUTY==MAX).
  - FSM = IDLE, timer = 0.
  - Reset mid-press: the button must be released and re-pressed before any step is taken, because the edge register is reset to the current level.
- Input edge detect:
  - Registers up_q/dn_q hold the previous levels.
  - rise_up = pb_up & ~up_q; rise_dn likewise.
  - During reset, up_q <= pb_up and dn_q <= pb_down.
- Step operation (MAX = 2^WIDTH-1):
  - up: duty <= min(duty+STEP, MAX).
  - down: duty <= max(duty-STEP, 0).
  - Compute in WIDTH+1 bits; never wrap.
- FSM, states IDLE / HOLD / REPEAT:
  - IDLE: rise_up with pb_down=0 -> step up, timer=0, dir=up, go to HOLD. rise_dn with pb_up=0 -> step down, dir=down, go to HOLD. Both high, or simultaneous rises -> no step, stay IDLE.
  - HOLD: the active button is released, or the other button is pressed -> IDLE, no step. Otherwise timer increments; when timer == HOLD_CYCLES-1 -> step in dir, timer=0, go to REPEAT.
  - REPEAT: same release/conflict exit to IDLE. Otherwise timer increments; when timer == REPEAT_CYCLES-1 -> step, timer=0.
  - Steps at a limit keep saturating; duty holds, and the FSM still cycles.
- Timing of duty: duty updates on the clock edge after the triggering condition (1-cycle latency from the rise at the input to the duty change).
- PWM:
  - cnt increments every clock and wraps MAX -> 0.
  - When cnt == MAX, duty_active <= duty. The new duty is used from cnt == 0 of the next period, so it is never changed mid-period.
  - pwm_out <= (cnt < duty_active), which gives a registered 1-cycle delay.
  - duty 0 gives a constant 0; duty MAX gives MAX high cycles per 2^WIDTH.
- at_limit is registered from the new duty value, updating in the same cycle as duty.

Test Plan (bench params: WIDTH=4, STEP=3, INIT_DUTY=8, HOLD_CYCLES=8, REPEAT_CYCLES=4):
- Reset release -> duty=8, pwm_out=0, at_limit=0; steady state gives pwm_out high 8 of every 16 cycles, rising one cycle after cnt=0.
- Single pb_up pulse of 3 cycles -> duty=11 one cycle after the rise, no further steps. The next period after the cnt==15 boundary shows 11 high cycles. The period already in progress keeps 8.
- Hold pb_up for 30 cycles from duty=8:
  - Step to 11 at the press.
  - Step to 14 after 8 cycles.
  - Step to 15 after 4 more cycles, then saturates at 15 with at_limit=1.
  - No further change after release.
- From duty=2, pb_down press -> duty=0 (saturated, no wrap), at_limit=1, pwm_out constantly 0 from the next period.
- pb_up and pb_down rising in the same cycle -> duty unchanged. Pressing pb_down while pb_up is held in HOLD -> return to IDLE, no repeat steps.
- Assert rst while in REPEAT with pb_up held -> duty=INIT_DUTY=8, cnt=0; after rst deasserts with pb_up still high, no step until pb_up is released and pressed again.
